adder_arb: RTL and testbench

Round-robin scheduler sharing one registered 32-bit adder datapath among NREQ requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester at a time, latches its operands into the adder's operand registers, registers the sum, and returns it tagged with the requester index over a backpressured response channel. It sits between multiple compute clients and the single adder instance in the power-experiment datapath.

---
 rtl/adder_arb.sv | 171 +++++++++++++++++
 tb/tb_adder_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arb.sv
// ----------------------------------------------------------------------------
// adder_arb
//
// Round-robin scheduler that shares one registered W-bit adder among NREQ
// requesters. A winner is picked in IDLE by scanning req_valid from rr_ptr,
// its operands are latched, the sum is registered in ADD, and the tagged
// result is offered in RESP until the consumer accepts it. One operation is
// in flight at a time.
//
// Optional feature macro: ADDER_ARB_COUT_EN
//   defined   -> carry out of the add is registered and driven on rsp_cout
//   undefined -> rsp_cout port and carry register are absent, sum wraps
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   [NREQ]    per-requester operand-pair valid
//   req_ready  out  [NREQ]    one-hot grant (IDLE only) or zero
//   req_a      in   [NREQ*W]  operand a, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]  operand b, same packing
//   rsp_valid  out            response available (RESP state)
//   rsp_ready  in             consumer accepts response
//   rsp_id     out  [IDW]     requester index owning the response
//   rsp_sum    out  [W]       (a + b) mod 2^W
//   busy       out            FSM not in IDLE
//   rsp_cout   out            carry out (ADDER_ARB_COUT_EN only)
// ----------------------------------------------------------------------------
module adder_arb #(
    parameter int unsigned W    = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
`ifdef ADDER_ARB_COUT_EN
    output logic              rsp_cout,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q,  state_d;
    logic [W-1:0]   reg_a_q,  reg_a_d;
    logic [W-1:0]   reg_b_q,  reg_b_d;
    logic [W-1:0]   reg_s_q,  reg_s_d;
    logic [IDW-1:0] reg_id_q, reg_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`ifdef ADDER_ARB_COUT_EN
    logic           reg_c_q,  reg_c_d;
    logic [W:0]     sum_full;
`else
    logic [W-1:0]   sum_full;
`endif

    logic            found;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic            transfer;
    int unsigned     scan_idx;

    // Rotating priority scan: offset k from rr_ptr, wrapped without a modulo
    // so non-power-of-two NREQ works.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req_valid[scan_idx[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[IDW-1:0];
            end
        end
        grant_vec = found ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

    // Gated by reset so the grant reads zero while reset is asserted.
    assign req_ready = (state_q == ST_IDLE && reset) ? grant_vec : '0;
    assign transfer  = |(req_valid & req_ready);

`ifdef ADDER_ARB_COUT_EN
    assign sum_full = {1'b0, reg_a_q} + {1'b0, reg_b_q};
`else
    assign sum_full = reg_a_q + reg_b_q;
`endif

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_s_d  = reg_s_q;
        reg_id_d = reg_id_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ADDER_ARB_COUT_EN
        reg_c_d  = reg_c_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    reg_a_d  = req_a[32'(grant_idx)*W +: W];
                    reg_b_d  = req_b[32'(grant_idx)*W +: W];
                    reg_id_d = grant_idx;
                    rr_ptr_d = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                reg_s_d = sum_full[W-1:0];
`ifdef ADDER_ARB_COUT_EN
                reg_c_d = sum_full[W];
`endif
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_s_q  <= '0;
            reg_id_q <= '0;
            rr_ptr_q <= '0;
`ifdef ADDER_ARB_COUT_EN
            reg_c_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_s_q  <= reg_s_d;
            reg_id_q <= reg_id_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ADDER_ARB_COUT_EN
            reg_c_q  <= reg_c_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = reg_id_q;
    assign rsp_sum   = reg_s_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef ADDER_ARB_COUT_EN
    assign rsp_cout  = reg_c_q;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// ----------------------------------------------------------------------------
// tb_adder_arb
//
// Directed self-checking bench for adder_arb (W=32, NREQ=4, IDW=2). Inputs
// are driven 1 ns after the rising edge and outputs compared 1 ns later, so
// every check is well away from the active edge. With ADDER_ARB_COUT_EN
// defined the carry output is connected and checked as well.
// ----------------------------------------------------------------------------
module tb_adder_arb;

    localparam int unsigned W    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              busy;
`ifdef ADDER_ARB_COUT_EN
    logic              rsp_cout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    adder_arb #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef ADDER_ARB_COUT_EN
        .rsp_cout  (rsp_cout),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle: land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'd0) begin n_err++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef ADDER_ARB_COUT_EN
        n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL reset_rsp_cout got=%b exp=0", rsp_cout); end
`endif
        req_valid = '0;
        reset     = 1'b1;
        #1;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a[0 +: W] = 32'd5;
        req_b[0 +: W] = 32'd7;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_T got=%b exp=0", busy); end
        step();
        req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_T1 got=%b exp=1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_valid_T1 got=%b exp=0", rsp_valid); end
        step();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid_T2 got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'd12) begin n_err++; $display("FAIL single_rsp_sum got=%0d exp=12", rsp_sum); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_T2 got=%b exp=1", busy); end
`ifdef ADDER_ARB_COUT_EN
        n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL single_rsp_cout got=%b exp=0", rsp_cout); end
`endif
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_T3 got=%b exp=0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_valid_T3 got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_id [5];
        logic [31:0] exp_sum [4];
        logic [3:0]  exp_gnt;
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        // a_i = 1000*(i+1), b_i = i+7
        exp_sum = '{32'd1007, 32'd2008, 32'd3009, 32'd4010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*W +: W] = 32'(1000 * (i + 1));
            req_b[i*W +: W] = 32'(i + 7);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << exp_id[g];
            n_cmp++; if (req_ready !== exp_gnt) begin n_err++; $display("FAIL rr_grant[%0d] got=%b exp=%b", g, req_ready, exp_gnt); end
            step();
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_ready_add[%0d] got=%b exp=0000", g, req_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=1", g, rsp_valid); end
            n_cmp++; if (rsp_id !== exp_id[g]) begin n_err++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", g, rsp_id, exp_id[g]); end
            n_cmp++; if (rsp_sum !== exp_sum[exp_id[g]]) begin n_err++; $display("FAIL rr_rsp_sum[%0d] got=%0d exp=%0d", g, rsp_sum, exp_sum[exp_id[g]]); end
            if (g == 4) req_valid = '0;
            step();
        end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_idle_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_gnt [3];
        logic [1:0] exp_id  [3];
        exp_gnt = '{4'b0001, 4'b0100, 4'b0001};
        exp_id  = '{2'd0, 2'd2, 2'd0};
        do_reset();
        rsp_ready = 1'b1;
        // Grant requester 2 alone so rr_ptr lands on 3.
        req_valid = 4'b0100;
        req_a[2*W +: W] = 32'd20;
        req_b[2*W +: W] = 32'd22;
        req_a[0 +: W]   = 32'd100;
        req_b[0 +: W]   = 32'd1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_setup_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b0101;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_cmp++; if (req_ready !== exp_gnt[g]) begin n_err++; $display("FAIL wrap_grant[%0d] got=%b exp=%b", g, req_ready, exp_gnt[g]); end
            step();
            step();
            n_cmp++; if (rsp_id !== exp_id[g]) begin n_err++; $display("FAIL wrap_rsp_id[%0d] got=%0d exp=%0d", g, rsp_id, exp_id[g]); end
            if (g == 2) req_valid = '0;
            step();
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        req_a[1*W +: W] = 32'h1234_0000;
        req_b[1*W +: W] = 32'h0000_5678;
        req_a[3*W +: W] = 32'd3;
        req_b[3*W +: W] = 32'd4;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b1000;
        step();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", c, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_rsp_id[%0d] got=%0d exp=1", c, rsp_id); end
            n_cmp++; if (rsp_sum !== 32'h1234_5678) begin n_err++; $display("FAIL bp_rsp_sum[%0d] got=%h exp=12345678", c, rsp_sum); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_req_ready[%0d] got=%b exp=0000", c, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant_at_rsp got=%b exp=0000", req_ready); end
        step();
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
        step();
        req_valid = '0;
        step();
        n_cmp++; if (rsp_id !== 2'd3) begin n_err++; $display("FAIL bp_next_rsp_id got=%0d exp=3", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'd7) begin n_err++; $display("FAIL bp_next_rsp_sum got=%0d exp=7", rsp_sum); end
        step();
    endtask

    task automatic test_overflow();
        req_valid = 4'b0001;
        req_a[0 +: W] = 32'hFFFF_FFFF;
        req_b[0 +: W] = 32'h0000_0002;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ovf_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        step();
        n_cmp++; if (rsp_sum !== 32'h0000_0001) begin n_err++; $display("FAIL ovf_rsp_sum got=%h exp=00000001", rsp_sum); end
`ifdef ADDER_ARB_COUT_EN
        n_cmp++; if (rsp_cout !== 1'b1) begin n_err++; $display("FAIL ovf_rsp_cout got=%b exp=1", rsp_cout); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        req_a[2*W +: W] = 32'hFFFF_FFFF;
        req_b[2*W +: W] = 32'h0000_0010;
        req_a[0 +: W]   = 32'd40;
        req_b[0 +: W]   = 32'd2;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_add got=%b exp=1", busy); end
        // Asynchronous assertion in the middle of the ADD cycle.
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'd0) begin n_err++; $display("FAIL mid_rsp_sum got=%h exp=0", rsp_sum); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_req_ready got=%b exp=0000", req_ready); end
        step();
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale_rsp got=%b exp=0", rsp_valid); end
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        step();
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_rsp_id_after got=%0d exp=0", rsp_id); end
        n_cmp++; if (rsp_sum !== 32'd42) begin n_err++; $display("FAIL mid_rsp_sum_after got=%0d exp=42", rsp_sum); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
